// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: synced, debounced, rule-checked and queued direction input for the snake game core
module snake_dir_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         QUEUE_DEPTH     = 2,
    parameter logic [1:0] RESET_DIR       = 2'd3
) (
    input  logic                          CLOCK_50,
    input  logic                          rst,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          step,
    output logic [1:0]                    dir,
    output logic                          dir_changed,
    output logic [$clog2(QUEUE_DEPTH):0]  q_count,
    output logic                          drop
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]    w_raw;
    logic [3:0]    r_s1, r_s2, r_stable, r_prev;
    logic [CW-1:0] r_cnt [4];
    logic [1:0]    r_mem [QUEUE_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic [1:0]    r_dir;
    logic          r_dir_changed, r_drop;
    logic [3:0]    w_press;
    logic [1:0]    w_cand, w_ref;
    logic          w_any, w_multi, w_pop, w_ok;

    // bit index equals the direction code: UP=0, DOWN=1, LEFT=2, RIGHT=3
    assign w_raw = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_stable <= '0;
            r_prev   <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_s1   <= w_raw;
            r_s2   <= r_s1;
            r_prev <= r_stable;
            for (int i = 0; i < 4; i++)
                if (r_s2[i] == r_stable[i])
                    r_cnt[i] <= '0;
                else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else
                    r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    always_comb begin
        w_press = r_stable & ~r_prev;
        w_any   = |w_press;
        w_multi = (w_press & (w_press - 4'd1)) != 4'd0;
        w_cand  = w_press[0] ? 2'd0 : w_press[1] ? 2'd1 : w_press[2] ? 2'd2 : 2'd3;
        w_pop   = step && r_count != '0;
        // new turns are judged against the last queued turn, not the current heading
        w_ref   = r_count != '0 ? r_mem[r_wp - 1'b1] : r_dir;
        w_ok    = w_any && w_cand != w_ref && w_cand != (w_ref ^ 2'b01) && (!r_count[AW] || w_pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_count       <= '0;
            r_dir         <= RESET_DIR;
            r_dir_changed <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            if (w_ok) begin
                r_mem[r_wp] <= w_cand;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_dir <= r_mem[r_rp];
                r_rp  <= r_rp + 1'b1;
            end
            r_count       <= r_count + (AW+1)'(w_ok) - (AW+1)'(w_pop);
            r_dir_changed <= w_pop;
            r_drop        <= w_multi || (w_any && !w_ok);
        end
    end

    assign dir         = r_dir;
    assign dir_changed = r_dir_changed;
    assign q_count     = r_count;
    assign drop        = r_drop;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed checks of debounce latency, turn rules, queue and reset
module tb_snake_dir_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       step;
    logic [1:0] dir;
    logic       dir_changed;
    logic [1:0] q_count;
    logic       drop;
    int         n_chk = 0;
    int         n_err = 0;
    int         q0;
    int         seen;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2), .RESET_DIR(2'd3)) dut (
        .CLOCK_50(clk), .rst(rst),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
        .step(step), .dir(dir), .dir_changed(dir_changed), .q_count(q_count), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // raw rise lands in the queue on the 7th edge; s optionally fires step on that edge
    task automatic press(input logic [3:0] m, input logic s);
        q0  = int'(q_count);
        btn = m;
        repeat (6) @(negedge clk);
        chk("lat6_q", int'(q_count), q0);
        step = s;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic release_all();
        btn = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        btn  = 4'b0000;
        step = 1'b0;
        do_reset();
        chk("rst_dir", dir, 3);
        chk("rst_q", q_count, 0);
        chk("rst_dc", dir_changed, 0);
        chk("rst_drop", drop, 0);

        btn  = 4'b0010;
        repeat (3) @(negedge clk);
        btn  = 4'b0000;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (drop || q_count != 2'd0) seen = 1;
        end
        chk("glitch_quiet", seen, 0);

        press(4'b0100, 1'b0);
        chk("rev_q", q_count, 0);
        chk("rev_drop", drop, 1);
        @(negedge clk);
        chk("rev_drop_pulse", drop, 0);
        release_all();
        press(4'b1000, 1'b0);
        chk("same_q", q_count, 0);
        chk("same_drop", drop, 1);
        release_all();

        press(4'b0001, 1'b0);
        chk("up_q7", q_count, 1);
        chk("up_drop", drop, 0);
        release_all();
        press(4'b0100, 1'b0);
        chk("left_q", q_count, 2);
        chk("left_drop", drop, 0);
        release_all();
        press(4'b0010, 1'b0);
        chk("full_q", q_count, 2);
        chk("full_drop", drop, 1);
        release_all();

        do_step();
        chk("s1_dir", dir, 0);
        chk("s1_dc", dir_changed, 1);
        chk("s1_q", q_count, 1);
        do_step();
        chk("s2_dir", dir, 2);
        chk("s2_q", q_count, 0);
        do_step();
        chk("s3_dir", dir, 2);
        chk("s3_dc", dir_changed, 0);
        chk("s3_q", q_count, 0);
        chk("s3_drop", drop, 0);

        press(4'b0001, 1'b0);
        chk("f_up_q", q_count, 1);
        release_all();
        press(4'b1000, 1'b0);
        chk("f_right_q", q_count, 2);
        release_all();
        press(4'b0010, 1'b1);
        chk("co_q", q_count, 2);
        chk("co_dir", dir, 0);
        chk("co_dc", dir_changed, 1);
        chk("co_drop", drop, 0);
        release_all();

        do_reset();
        chk("rf_q", q_count, 0);
        chk("rf_dir", dir, 3);
        chk("rf_dc", dir_changed, 0);
        chk("rf_drop", drop, 0);

        press(4'b0101, 1'b0);
        chk("multi_q", q_count, 1);
        chk("multi_drop", drop, 1);
        release_all();
        do_step();
        chk("multi_dir", dir, 0);
        chk("multi_q0", q_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
